// File: rtl/mc_seq_port_sched.sv
// Multi-cycle port allocator: walks up to four ranked flits one per cycle, granting
// free output ports in priority order, then holds the allocated vectors until ack.
module mc_seq_port_sched #(
    parameter int NPORT        = 4,
    parameter bit SKIP_INVALID = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       valid_in,
    input  logic [3:0]       mc_in,
    input  logic [NPORT-1:0] ppv_0,
    input  logic [NPORT-1:0] ppv_1,
    input  logic [NPORT-1:0] ppv_2,
    input  logic [NPORT-1:0] ppv_3,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [NPORT-1:0] allocPV_0,
    output logic [NPORT-1:0] allocPV_1,
    output logic [NPORT-1:0] allocPV_2,
    output logic [NPORT-1:0] allocPV_3,
    output logic [3:0]       starve
);

    typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       vld_q, mc_q, pend;
    logic [NPORT-1:0] ppv_q [4];
    logic [NPORT-1:0] apv_q [4];
    logic [NPORT-1:0] avail;
    logic [1:0]       rank, cur_rank;
    logic [3:0]       starve_q;

    logic [NPORT-1:0] cand, grant;
    logic             cur_vld, cur_starve, last;

    function automatic logic [NPORT-1:0] lowbit(input logic [NPORT-1:0] x);
        return x & (~x + NPORT'(1));
    endfunction

    // With skipping, the rank under service is the lowest still-pending valid rank.
    always_comb begin
        cur_rank = rank;
        if (SKIP_INVALID) begin
            cur_rank = 2'd0;
            for (int i = 3; i >= 0; i--)
                if (pend[i]) cur_rank = 2'(i);
        end
    end

    always_comb begin
        cur_vld    = vld_q[cur_rank];
        cand       = ppv_q[cur_rank] & avail;
        grant      = '0;
        cur_starve = 1'b0;
        if (cur_vld) begin
            if (mc_q[cur_rank] && cand != '0) grant = cand;
            else if (cand != '0)              grant = lowbit(cand);
            else if (avail != '0)             grant = lowbit(avail);
            else                              cur_starve = 1'b1;
        end
        if (SKIP_INVALID) last = (pend & ~(4'b0001 << cur_rank)) == 4'b0000;
        else              last = (rank == 2'd3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ALLOC;
            S_ALLOC: if (last)  state_nxt = S_DONE;
            S_DONE:  if (ack)   state_nxt = S_IDLE;
            default:            state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_ALLOC) || (state == S_DONE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q    <= '0;
            mc_q     <= '0;
            pend     <= '0;
            avail    <= '1;
            rank     <= '0;
            starve_q <= '0;
            for (int i = 0; i < 4; i++) begin
                ppv_q[i] <= '0;
                apv_q[i] <= '0;
            end
        end else if (state == S_IDLE && start) begin
            vld_q    <= valid_in;
            mc_q     <= mc_in;
            pend     <= valid_in;
            ppv_q[0] <= ppv_0;
            ppv_q[1] <= ppv_1;
            ppv_q[2] <= ppv_2;
            ppv_q[3] <= ppv_3;
            avail    <= '1;
            rank     <= '0;
            starve_q <= '0;
            for (int i = 0; i < 4; i++) apv_q[i] <= '0;
        end else if (state == S_ALLOC) begin
            apv_q[cur_rank]    <= grant;
            starve_q[cur_rank] <= cur_starve;
            avail              <= avail & ~grant;
            pend[cur_rank]     <= 1'b0;
            if (!last) rank <= rank + 2'd1;
        end
    end

    assign allocPV_0 = apv_q[0];
    assign allocPV_1 = apv_q[1];
    assign allocPV_2 = apv_q[2];
    assign allocPV_3 = apv_q[3];
    assign starve    = starve_q;

endmodule
